cook_time_setter: RTL and testbench

//   Front-panel controller that writes the cook-time settings consumed by time_count.

---
 rtl/cook_time_setter_if.sv | 28 ++
 rtl/cook_time_setter.sv | 155 +++++++++++++++
 tb/tb_cook_time_setter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cook_time_setter_if.sv
// Front-panel signal bundle between the button/timer side and cook_time_setter.
// The slave modport is the controller's view; master is the driving side.
interface cook_time_setter_if;
  logic       btn_sec;
  logic       btn_min;
  logic       btn_start;
  logic       btn_clear;
  logic       count_zero;
  logic [3:0] seconds_prog;
  logic [3:0] tens_seconds_prog;
  logic [3:0] minutes_prog;
  logic [3:0] tens_minutes_prog;
  logic       load;
  logic       timer_on;
  logic       alarm;

  modport master (
    output btn_sec, btn_min, btn_start, btn_clear, count_zero,
    input  seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
    input  load, timer_on, alarm
  );

  modport slave (
    input  btn_sec, btn_min, btn_start, btn_clear, count_zero,
    output seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
    output load, timer_on, alarm
  );
endinterface

// File: rtl/cook_time_setter.sv
// Cook-time front panel: turns debounced buttons into four BCD programmed digits,
// drives load/timer_on toward time_count and raises the alarm at countdown expiry.
module cook_time_setter #(
  parameter int unsigned REPEAT_DELAY = 5,
  parameter int unsigned REPEAT_RATE  = 2,
  parameter int unsigned ALARM_CYCLES = 300,
  parameter int unsigned CTR_WIDTH    = 9
) (
  input logic               clk,
  input logic               reset,
  cook_time_setter_if.slave bus
);
  localparam logic [1:0] SET   = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] ALARM = 2'd3;

  localparam logic [CTR_WIDTH-1:0] RPT_FIRE   = CTR_WIDTH'(REPEAT_DELAY);
  localparam logic [CTR_WIDTH-1:0] RPT_LAST   = CTR_WIDTH'(REPEAT_DELAY + REPEAT_RATE - 1);
  localparam logic [CTR_WIDTH-1:0] ALARM_LAST = CTR_WIDTH'(ALARM_CYCLES - 1);

  logic [1:0]           state, state_nx;
  logic [3:0]           sec, tsec, min, tmin;
  logic [3:0]           sec_nx, tsec_nx, min_nx, tmin_nx;
  logic                 sec_d, min_d, start_d, clear_d;
  logic [CTR_WIDTH-1:0] sec_rpt, min_rpt, alarm_cnt;
  logic [CTR_WIDTH-1:0] sec_rpt_nx, min_rpt_nx, alarm_cnt_nx;
  logic                 load_q, load_nx;
  logic                 sec_press, min_press, start_press, clear_press;
  logic                 sec_inc, min_inc, in_set, nonzero;

  assign sec_press   = bus.btn_sec   & ~sec_d;
  assign min_press   = bus.btn_min   & ~min_d;
  assign start_press = bus.btn_start & ~start_d;
  assign clear_press = bus.btn_clear & ~clear_d;
  assign in_set      = (state == SET);
  assign nonzero     = |{sec, tsec, min, tmin};

  // Counter only arms on a real press, so a level held through reset never repeats.
  function automatic logic [CTR_WIDTH-1:0] rpt_next(input logic level, input logic press,
                                                    input logic [CTR_WIDTH-1:0] cnt,
                                                    input logic active);
    if (!active || !level || (!press && cnt == '0))
      return '0;
    return (cnt == RPT_LAST) ? RPT_FIRE : cnt + 1'b1;
  endfunction

  assign sec_rpt_nx = rpt_next(bus.btn_sec, sec_press, sec_rpt, in_set);
  assign min_rpt_nx = rpt_next(bus.btn_min, min_press, min_rpt, in_set);
  assign sec_inc    = in_set & bus.btn_sec & (sec_press | (sec_rpt == RPT_FIRE));
  assign min_inc    = in_set & bus.btn_min & (min_press | (min_rpt == RPT_FIRE));

  always_comb begin
    state_nx     = state;
    sec_nx       = sec;
    tsec_nx      = tsec;
    min_nx       = min;
    tmin_nx      = tmin;
    load_nx      = 1'b0;
    alarm_cnt_nx = '0;
    case (state)
      SET: begin
        if (clear_press) begin
          sec_nx  = '0;
          tsec_nx = '0;
          min_nx  = '0;
          tmin_nx = '0;
        end else begin
          if (sec_inc) begin
            if (sec == 4'd9) begin
              sec_nx  = '0;
              tsec_nx = (tsec == 4'd5) ? 4'd0 : tsec + 4'd1;
            end else begin
              sec_nx = sec + 4'd1;
            end
          end
          if (min_inc) begin
            if (min == 4'd9) begin
              min_nx  = '0;
              tmin_nx = (tmin == 4'd9) ? 4'd0 : tmin + 4'd1;
            end else begin
              min_nx = min + 4'd1;
            end
          end
          if (start_press && nonzero) begin
            load_nx  = 1'b1;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        // load_q high marks the cycle time_count is still taking the new value.
        if (clear_press)
          state_nx = SET;
        else if (bus.count_zero && !load_q)
          state_nx = ALARM;
        else if (start_press)
          state_nx = PAUSE;
      end
      PAUSE: begin
        if (clear_press)
          state_nx = SET;
        else if (start_press)
          state_nx = RUN;
      end
      ALARM: begin
        if (clear_press || start_press || alarm_cnt == ALARM_LAST)
          state_nx = SET;
        else
          alarm_cnt_nx = alarm_cnt + 1'b1;
      end
      default: state_nx = SET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SET;
      sec       <= '0;
      tsec      <= '0;
      min       <= '0;
      tmin      <= '0;
      load_q    <= 1'b0;
      sec_rpt   <= '0;
      min_rpt   <= '0;
      alarm_cnt <= '0;
      sec_d     <= 1'b1;
      min_d     <= 1'b1;
      start_d   <= 1'b1;
      clear_d   <= 1'b1;
    end else begin
      state     <= state_nx;
      sec       <= sec_nx;
      tsec      <= tsec_nx;
      min       <= min_nx;
      tmin      <= tmin_nx;
      load_q    <= load_nx;
      sec_rpt   <= sec_rpt_nx;
      min_rpt   <= min_rpt_nx;
      alarm_cnt <= alarm_cnt_nx;
      sec_d     <= bus.btn_sec;
      min_d     <= bus.btn_min;
      start_d   <= bus.btn_start;
      clear_d   <= bus.btn_clear;
    end
  end

  assign bus.seconds_prog      = sec;
  assign bus.tens_seconds_prog = tsec;
  assign bus.minutes_prog      = min;
  assign bus.tens_minutes_prog = tmin;
  assign bus.load              = load_q;
  assign bus.timer_on          = (state == RUN);
  assign bus.alarm             = (state == ALARM);
endmodule

// File: tb/tb_cook_time_setter.sv
// Self-checking bench for cook_time_setter: expected outputs are queued as each
// stimulus cycle is driven and compared after the following clock edge.
module tb_cook_time_setter;
  logic clk = 1'b0;
  logic reset;

  cook_time_setter_if bus();

  cook_time_setter #(
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2),
    .ALARM_CYCLES(300),
    .CTR_WIDTH   (9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  string       exp_tag[$];
  logic [18:0] exp_val[$];
  int          es, em;
  logic        e_on, e_al;

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got time=%h ld/on/al=%b, expected time=%h ld/on/al=%b",
               tag, obs[18:3], obs[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  function automatic logic [18:0] pack(input int m, input int s, input logic ld,
                                       input logic on, input logic al);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), ld, on, al};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.tens_minutes_prog, bus.minutes_prog, bus.tens_seconds_prog,
            bus.seconds_prog, bus.load, bus.timer_on, bus.alarm};
  endfunction

  // Queue the expectation for the inputs currently driven, clock, then score.
  task automatic step(input string tag, input logic ld);
    exp_tag.push_back(tag);
    exp_val.push_back(pack(em, es, ld, e_on, e_al));
    @(posedge clk);
    #1;
    while (exp_val.size() > 0)
      check(exp_tag.pop_front(), observed(), exp_val.pop_front());
  endtask

  task automatic press_sec();
    bus.btn_sec = 1'b1; es = (es + 1) % 60; step("sec_press", 1'b0);
    bus.btn_sec = 1'b0; step("sec_release", 1'b0);
  endtask

  task automatic press_min();
    bus.btn_min = 1'b1; em = (em + 1) % 100; step("min_press", 1'b0);
    bus.btn_min = 1'b0; step("min_release", 1'b0);
  endtask

  task automatic press_clear_set();
    bus.btn_clear = 1'b1; es = 0; em = 0; step("clear_set", 1'b0);
    bus.btn_clear = 1'b0; step("clear_release", 1'b0);
  endtask

  initial begin
    es = 0; em = 0; e_on = 1'b0; e_al = 1'b0;
    bus.btn_sec = 1'b1; bus.btn_min = 1'b0; bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0; bus.count_zero = 1'b0;
    reset = 1'b1;

    // Reset with btn_sec held: nothing fires, no auto-repeat afterwards.
    step("reset", 1'b0);
    step("reset", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step("held_through_reset", 1'b0);
    bus.btn_sec = 1'b0;
    step("held_release", 1'b0);

    // Seconds wrap 59 -> 00 without touching minutes; minutes wrap 99 -> 00.
    for (int i = 0; i < 58; i++) press_sec();
    for (int i = 0; i < 3; i++) press_sec();
    for (int i = 0; i < 98; i++) press_min();
    for (int i = 0; i < 12; i++) press_min();

    // Simultaneous +sec/+min both apply.
    bus.btn_sec = 1'b1; bus.btn_min = 1'b1;
    es = (es + 1) % 60; em = (em + 1) % 100;
    step("sec_min_same_cycle", 1'b0);
    bus.btn_sec = 1'b0; bus.btn_min = 1'b0;
    step("sec_min_release", 1'b0);

    // Auto-repeat: hold btn_min 11 cycles from zero.
    press_clear_set();
    bus.btn_min = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 0 || (k >= 5 && (k - 5) % 2 == 0)) em = (em + 1) % 100;
      step("min_hold", 1'b0);
    end
    bus.btn_min = 1'b0;
    step("min_hold_release", 1'b0);
    check("min_hold_total", {15'd0, bus.minutes_prog}, 19'd4);

    // Program 12:34 and start; count_zero high from the load cycle.
    press_clear_set();
    for (int i = 0; i < 12; i++) press_min();
    for (int i = 0; i < 34; i++) press_sec();
    bus.btn_start = 1'b1; e_on = 1'b1;
    step("start_load", 1'b1);
    bus.btn_start = 1'b0; bus.count_zero = 1'b1;
    step("load_plus1_no_alarm", 1'b0);
    e_on = 1'b0; e_al = 1'b1;
    step("alarm_at_load_plus2", 1'b0);
    bus.count_zero = 1'b0;
    for (int k = 1; k < 300; k++) step("alarm_hold", 1'b0);
    e_al = 1'b0;
    step("alarm_timeout_set", 1'b0);

    // RUN / PAUSE / resume without load; +sec ignored outside SET.
    bus.btn_start = 1'b1; e_on = 1'b1;
    step("run_load", 1'b1);
    bus.btn_start = 1'b0;
    step("run", 1'b0);
    bus.btn_sec = 1'b1;
    step("sec_ignored_run", 1'b0);
    bus.btn_sec = 1'b0;
    step("run", 1'b0);
    bus.btn_start = 1'b1; e_on = 1'b0;
    step("pause", 1'b0);
    bus.btn_start = 1'b0; bus.count_zero = 1'b1;
    step("pause_ignores_zero", 1'b0);
    bus.count_zero = 1'b0;
    bus.btn_start = 1'b1; e_on = 1'b1;
    step("resume_no_load", 1'b0);
    bus.btn_start = 1'b0;
    step("run", 1'b0);
    bus.btn_start = 1'b1; bus.btn_clear = 1'b1; e_on = 1'b0;
    step("run_clear_beats_start", 1'b0);
    bus.btn_start = 1'b0; bus.btn_clear = 1'b0;
    step("set_retained", 1'b0);

    // Alarm cut short by a clear press.
    bus.btn_start = 1'b1; e_on = 1'b1;
    step("rerun_load", 1'b1);
    bus.btn_start = 1'b0; bus.count_zero = 1'b1;
    step("rerun_load_plus1", 1'b0);
    e_on = 1'b0; e_al = 1'b1;
    step("rerun_alarm", 1'b0);
    bus.count_zero = 1'b0;
    for (int k = 0; k < 10; k++) step("alarm_mid", 1'b0);
    bus.btn_clear = 1'b1; e_al = 1'b0;
    step("alarm_clear_exit", 1'b0);
    bus.btn_clear = 1'b0;
    step("set_after_alarm", 1'b0);

    // In SET, clear beats start; start with zero setting is ignored.
    bus.btn_clear = 1'b1; bus.btn_start = 1'b1; es = 0; em = 0;
    step("set_clear_beats_start", 1'b0);
    bus.btn_clear = 1'b0; bus.btn_start = 1'b0;
    step("set_idle", 1'b0);
    bus.btn_start = 1'b1;
    step("start_zero_ignored", 1'b0);
    bus.btn_start = 1'b0;
    step("set_idle", 1'b0);

    // Reset mid-run returns everything to zero.
    press_sec();
    bus.btn_start = 1'b1; e_on = 1'b1;
    step("pre_reset_load", 1'b1);
    bus.btn_start = 1'b0;
    step("pre_reset_run", 1'b0);
    reset = 1'b1; es = 0; em = 0; e_on = 1'b0;
    step("reset_mid_run", 1'b0);
    reset = 1'b0;
    step("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
